// File: rtl/otter_pkg.sv
// Shared types and defaults for the OTTER register scoreboard.
package otter_pkg;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [CNT_W-1:0] scb_cnt_t;
endpackage

// File: rtl/scb_entry.sv
// One register's in-flight writer counter: +inc, -dec_a, -dec_b per cycle, clamped,
// with a registered busy flag and combinational underflow/overflow attempt flags.
module scb_entry
  import otter_pkg::*;
#(
  parameter int W = otter_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec_a,
  input  logic         dec_b,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         uflow,
  output logic         oflow
);
  localparam int SW = W + 2;
  localparam logic [SW-1:0] MAXV = SW'({W{1'b1}});

  logic [W-1:0]  cnt_q, cnt_d;
  logic          busy_q;
  logic [SW-1:0] add_w, sub_w, diff_w;

  // Two spare bits let the net result go below zero or above max before clamping.
  always_comb begin
    add_w  = {2'b00, cnt_q} + SW'(inc);
    sub_w  = SW'(dec_a) + SW'(dec_b);
    diff_w = add_w - sub_w;
    uflow  = sub_w > add_w;
    oflow  = !uflow && (diff_w > MAXV);
    cnt_d  = diff_w[W-1:0];
    if (uflow)      cnt_d = '0;
    else if (oflow) cnt_d = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign count = cnt_q;
  assign busy  = busy_q;
endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the OTTER decode stage: per-register writer counts and stall.
// Optional feature: define SCB_STALL_CNT_EN to add the saturating stall_cycles counter port.
module reg_scoreboard
  import otter_pkg::*;
#(
  parameter int NREG  = otter_pkg::NREG,
  parameter int CNT_W = otter_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [4:0]      issue_rd,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  output logic            stall,
  input  logic            retire_valid,
  input  logic [4:0]      retire_rd,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  output logic [NREG-1:0] busy_vec,
`ifdef SCB_STALL_CNT_EN
  output logic [31:0]     stall_cycles,
`endif
  output logic            err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] count;
  logic [NREG-1:0]            busy_w;
  logic [NREG-1:1]            inc_v, ret_v, kil_v, uflow_v, oflow_v;
  logic                       accept, stall_w;
  logic                       err_q, err_d;

  // x0 is never tracked: it reads as idle and never saturates.
  assign count[0]  = '0;
  assign busy_w[0] = 1'b0;

  // Stall looks only at registered state; a same-cycle retire does not bypass.
  assign stall_w = rst_n & issue_valid &
                   ((use_rs1 & busy_w[issue_rs1]) |
                    (use_rs2 & busy_w[issue_rs2]) |
                    (issue_wr & (count[issue_rd] == CNT_MAX)));
  assign accept  = issue_valid & ~stall_w;
  assign stall   = stall_w;

  always_comb begin
    inc_v = '0;
    ret_v = '0;
    kil_v = '0;
    for (int i = 1; i < NREG; i++) begin
      inc_v[i] = accept & issue_wr & (issue_rd == reg_idx_t'(i));
      ret_v[i] = retire_valid & (retire_rd == reg_idx_t'(i));
      kil_v[i] = kill_valid & (kill_rd == reg_idx_t'(i));
    end
  end

  for (genvar g = 1; g < NREG; g++) begin : g_ent
    scb_entry #(.W(CNT_W)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_v[g]),
      .dec_a (ret_v[g]),
      .dec_b (kil_v[g]),
      .count (count[g]),
      .busy  (busy_w[g]),
      .uflow (uflow_v[g]),
      .oflow (oflow_v[g])
    );
  end

  assign err_d = err_q | (|uflow_v) | (|oflow_v);

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign busy_vec = busy_w;
  assign err      = err_q;

`ifdef SCB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif
endmodule
